fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled only on the rising clk edge.
REQ-004 next_pc  input  16  redirect target produced by the PC adder stage.
REQ-005 redirect  input  1  branch/jump resolved taken; load next_pc.
REQ-006 stall  input  1  decode cannot accept; hold the output register.
REQ-007 halt  input  1  HALT decoded; stop fetching.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  16  read address, always equal to the PC register.
REQ-010 imem_ready  input  1  imem_data valid this cycle; completes the pending request.
REQ-011 imem_data  input  16  instruction word.
REQ-012 if_valid  output  1  if_instr, if_pc and if_pc_plus2 are valid.
REQ-013 if_instr  output  16  fetched instruction.
REQ-014 if_pc  output  16  address of if_instr; this is the basePC for the PC adder.
REQ-015 if_pc_plus2  output  16  if_pc + 2, modulo 2^16.
REQ-016 halted  output  1  the block is in HALTED.
REQ-017 err  output  1  sticky misaligned-redirect error.

Function
REQ-018 The block SHALL implement four states: FETCH, WAIT, HALTED, ERROR.
- FETCH: issue a request.
- WAIT: a request is outstanding.
REQ-019 In FETCH, the block SHALL drive imem_req=1 when (!if_valid || !stall), and imem_req=0 otherwise.
REQ-020 A request completes on a cycle with imem_req=1 and imem_ready=1; zero-wait memory completes in FETCH.
REQ-021 If imem_req=1 and imem_ready=0, the block SHALL enter WAIT; while in WAIT it SHALL hold imem_req=1 and imem_addr stable.
REQ-022 On completion, the block SHALL do all of the following on the next edge, then be in FETCH:
- if_instr<=imem_data;
- if_pc<=pc;
- if_pc_plus2<=pc+2;
- if_valid<=1;
- pc<=pc+2.
REQ-023 Response latency: completion at edge N SHALL make if_valid visible after edge N.
REQ-024 With if_valid=1 and stall=1, the block SHALL hold all if_* outputs unchanged.
REQ-025 With if_valid=1, stall=0 and no completion that cycle, the block SHALL set if_valid<=0.
REQ-026 PC arithmetic SHALL be 16-bit unsigned with wrap-around: 16'hFFFE+2=16'h0000.
REQ-027 On redirect=1 with next_pc[0]=0, the block SHALL, at the next edge:
- set pc<=next_pc;
- set if_valid<=0;
- go to FETCH;
- discard any response arriving that cycle.
A redirect in WAIT SHALL abandon the outstanding request.
REQ-028 On redirect=1 with next_pc[0]=1, the block SHALL set err<=1 and enter ERROR.
- ERROR: imem_req=0 and if_valid=0.
- err stays 1 until reset.
REQ-029 On halt=1 with redirect=0, the block SHALL enter HALTED.
- HALTED: imem_req=0, if_valid=0, halted=1.
- A completion that cycle SHALL be discarded.
REQ-030 HALTED and ERROR SHALL exit only via reset; all inputs are ignored in these states.
REQ-031 Priority per cycle SHALL be: reset > redirect > halt > stall > completion.
REQ-032 All outputs SHALL be driven from registers or state only; there is no combinational path from imem_data to any output.

Reset
REQ-033 When rst=0 at an edge, the block SHALL set:
- pc<=RESET_PC;
- state<=FETCH;
- if_valid<=0, if_instr<=0, if_pc<=0, if_pc_plus2<=0;
- halted<=0, err<=0.
REQ-034 While rst=0, imem_req SHALL be 0.
REQ-035 The first request SHALL be issued in the first cycle after rst returns to 1.
REQ-036 Reset asserted mid-WAIT SHALL drop the request; a late imem_ready after reset SHALL be ignored unless a new request is pending.

Verification
REQ-037 Zero-wait stream:
- Stimulus: release reset with imem_ready=1 and data 16'hA000+addr.
- Required response: consecutive if_pc values 0,2,4 and if_instr A000,A002,A004, if_pc_plus2 = if_pc+2.
REQ-038 Two wait cycles:
- Stimulus: imem_ready low for 2 cycles.
- Required response: imem_req=1 and imem_addr=0 held for 3 cycles, one if_valid pulse with if_pc=0.
REQ-039 Stall:
- Stimulus: stall=1 for 3 cycles while if_valid=1 with if_pc=4.
- Required response: outputs frozen at if_pc=4, imem_req=0, resume at pc 6.
REQ-040 Redirect during WAIT:
- Stimulus: redirect with next_pc=16'h0100, imem_ready asserted the same cycle.
- Required response: stale data discarded, next if_pc=16'h0100.
REQ-041 Wrap-around and halt:
- Stimulus: redirect to 16'hFFFE, then halt.
- Required response: if_pc=FFFE with if_pc_plus2=0000, next fetch at 0000; after halt, halted=1 and imem_req=0 until rst=0.
REQ-042 Misaligned redirect:
- Stimulus: redirect with next_pc=16'h0011.
- Required response: err=1, imem_req=0 permanently; reset clears err to 0 and the next fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// presents the fetched word with its address to decode.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t      state_r, state_nxt;
  logic [15:0] pc_r, pc_nxt;
  logic        if_valid_r, if_valid_nxt;
  logic [15:0] if_instr_r, if_instr_nxt;
  logic [15:0] if_pc_r, if_pc_nxt;
  logic [15:0] if_pc_plus2_r, if_pc_plus2_nxt;
  logic        err_r, err_nxt;
  logic        req_s;
  logic        done_s;
  logic [15:0] pc_plus2_s;

  assign pc_plus2_s = pc_r + 16'd2;

  // Memory request: held in WAIT, gated by decode back-pressure in FETCH, off in reset.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      FETCH:   req_s = !if_valid_r || !stall;
      WAIT:    req_s = 1'b1;
      default: req_s = 1'b0;
    endcase
    if (!rst) begin
      req_s = 1'b0;
    end else begin
      req_s = req_s;
    end
  end

  assign done_s = req_s && imem_ready;

  // Next-state and datapath: redirect > halt > stall > completion.
  always_comb begin
    state_nxt       = state_r;
    pc_nxt          = pc_r;
    if_valid_nxt    = if_valid_r;
    if_instr_nxt    = if_instr_r;
    if_pc_nxt       = if_pc_r;
    if_pc_plus2_nxt = if_pc_plus2_r;
    err_nxt         = err_r;
    case (state_r)
      FETCH, WAIT: begin
        if (redirect) begin
          if_valid_nxt = 1'b0;
          if (next_pc[0]) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = FETCH;
            pc_nxt    = next_pc;
          end
        end else if (halt) begin
          state_nxt    = HALTED;
          if_valid_nxt = 1'b0;
        end else if (if_valid_r && stall) begin
          state_nxt = state_r;
        end else if (done_s) begin
          state_nxt       = FETCH;
          if_instr_nxt    = imem_data;
          if_pc_nxt       = pc_r;
          if_pc_plus2_nxt = pc_plus2_s;
          if_valid_nxt    = 1'b1;
          pc_nxt          = pc_plus2_s;
        end else begin
          if_valid_nxt = 1'b0;
          if (req_s) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = state_r;
          end
        end
      end
      HALTED, ERROR: begin
        // Terminal until reset; keep the visible outputs quiet.
        if_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt    = ERROR;
        if_valid_nxt = 1'b0;
        err_nxt      = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      if_valid_r    <= 1'b0;
      if_instr_r    <= 16'h0000;
      if_pc_r       <= 16'h0000;
      if_pc_plus2_r <= 16'h0000;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      pc_r          <= pc_nxt;
      if_valid_r    <= if_valid_nxt;
      if_instr_r    <= if_instr_nxt;
      if_pc_r       <= if_pc_nxt;
      if_pc_plus2_r <= if_pc_plus2_nxt;
      err_r         <= err_nxt;
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign if_valid    = if_valid_r;
  assign if_instr    = if_instr_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus2 = if_pc_plus2_r;
  assign halted      = (state_r == HALTED);
  assign err         = err_r;

endmodule
